imem_arbiter: RTL and testbench

- Round-robin arbiter sharing the single-port program memory between instruction-fetch requesters, e.g. the vluint7 byte fetcher inside the decoder and the executor's literal/operand reader.
- Accepts at most one read per cycle and issues it to memory.
- Tracks which requester owns each in-flight read and routes the returned byte back with a per-requester valid pulse.
- Supports a lock so one requester can fetch a multi-byte varint without interleaving.

---
 rtl/imem_arbiter_pkg.sv | 24 ++
 rtl/imem_arbiter_rr_pick.sv | 30 +++
 rtl/imem_arbiter.sv | 104 ++++++++++
 tb/tb_imem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the program-memory arbiter and its users.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

package imem_arbiter_pkg;

  // Widest requester set the arbiter is sized for.
  localparam int IMEM_NREQ_MAX = 4;

  // Fixed requester slots on the program-memory port.
  localparam int REQ_DECODER = 0;
  localparam int REQ_EXEC    = 1;

  // One-hot owner tag carried alongside each in-flight read.
  typedef logic [IMEM_NREQ_MAX-1:0] imem_tag_t;

  // Ownership state of the memory port.
  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/imem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Output is one-hot or zero.
module imem_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [IW:0] idx;
  logic        found;

  // Walk the requesters from ptr, wrapping, and keep only the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && req[idx[IW-1:0]]) begin
        gnt[idx[IW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter for the single-port program memory. One read per cycle,
// owner tags follow each read through the fixed memory latency, and a lock
// lets one requester fetch a multi-byte varint without interleaving.
//
// lock_state | meaning
// -----------+------------------------------------------------------------
// LOCK_FREE  | normal round-robin among all requesters
// LOCK_HELD  | only requester lock_idx may be granted, even while it idles
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = `MEM_ADDR_WIDTH,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  lock_state_t     lock_state;
  logic [IW-1:0]   lock_idx;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] req_elig;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   gnt_idx;
  imem_tag_t       tag_pipe [MEM_LAT];

  // A held lock hides every request except the owner's.
  always_comb begin
    req_elig = req;
    if (lock_state == LOCK_HELD) req_elig = req & (NREQ'(1) << lock_idx);
  end

  imem_arbiter_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req (req_elig),
    .ptr (rr_ptr),
    .gnt (pick_gnt)
  );

  // Grant, strobe and address are combinational; nothing is granted in reset.
  always_comb begin
    gnt      = reset ? '0 : pick_gnt;
    mem_en   = |gnt;
    mem_addr = '0;
    gnt_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_addr = addr[i*AW +: AW];
        gnt_idx  = IW'(i);
      end
    end
  end

  // Lock FSM and round-robin pointer advance on every accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_state <= LOCK_FREE;
      lock_idx   <= '0;
      rr_ptr     <= '0;
    end else if (mem_en) begin
      rr_ptr     <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
      lock_idx   <= gnt_idx;
      lock_state <= lock[gnt_idx] ? LOCK_HELD : LOCK_FREE;
    end
  end

  // Owner tags ride alongside the memory latency; the last stage steers
  // the returned byte into the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < MEM_LAT; j++) tag_pipe[j] <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      tag_pipe[0] <= imem_tag_t'(gnt);
      for (int j = 1; j < MEM_LAT; j++) tag_pipe[j] <= tag_pipe[j-1];
      rvalid <= tag_pipe[MEM_LAT-1][NREQ-1:0];
      if (|tag_pipe[MEM_LAT-1]) rdata <= mem_rdata;
    end
  end

  // Busy while the port is locked or any read is still in the memory.
  always_comb begin
    busy = (lock_state == LOCK_HELD);
    for (int j = 0; j < MEM_LAT; j++) busy = busy | (|tag_pipe[j]);
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each fed by a behavioural memory returning addr[7:0]^8'hC5.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance
  logic [1:0]  req_a, lock_a, gnt_a, rvalid_a;
  logic [31:0] addr_a;
  logic [7:0]  rdata_a, mem_rdata_a;
  logic        mem_en_a, busy_a;
  logic [15:0] mem_addr_a;

  // MEM_LAT=3 instance
  logic [1:0]  req_b, lock_b, gnt_b, rvalid_b;
  logic [31:0] addr_b;
  logic [7:0]  rdata_b, mem_rdata_b;
  logic        mem_en_b, busy_b;
  logic [15:0] mem_addr_b;

  imem_arbiter #(.NREQ(2), .AW(16), .DW(8), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .lock(lock_a), .addr(addr_a),
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_en(mem_en_a),
    .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  imem_arbiter #(.NREQ(2), .AW(16), .DW(8), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .lock(lock_b), .addr(addr_b),
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_en(mem_en_b),
    .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hC5;
  endfunction

  // Behavioural memories with 1- and 3-cycle read latency.
  logic [7:0] ma1, mb1, mb2, mb3;
  always @(posedge clk) begin
    ma1 <= mem_byte(mem_addr_a);
    mb1 <= mem_byte(mem_addr_b);
    mb2 <= mb1;
    mb3 <= mb2;
  end
  assign mem_rdata_a = ma1;
  assign mem_rdata_b = mb3;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g [8];
  logic [7:0] exp_d [8];

  initial begin
    reset = 1'b1;
    req_a = '0; lock_a = '0; addr_a = '0;
    req_b = '0; lock_b = '0; addr_b = '0;
    step(); step();
    check("rst_gnt",    32'(gnt_a),      0);
    check("rst_rvalid", 32'(rvalid_a),   0);
    check("rst_rdata",  32'(rdata_a),    0);
    check("rst_mem_en", 32'(mem_en_a),   0);
    check("rst_maddr",  32'(mem_addr_a), 0);
    check("rst_busy",   32'(busy_a),     0);
    reset = 1'b0;
    step();

    // Single request: grant in the same cycle, data two cycles later.
    req_a = 2'b01; addr_a = {16'h0000, 16'h0040};
    #1;
    check("single_gnt",   32'(gnt_a),      32'h1);
    check("single_men",   32'(mem_en_a),   32'h1);
    check("single_maddr", 32'(mem_addr_a), 32'h40);
    step();
    req_a = 2'b00;
    #1;
    check("single_busy",   32'(busy_a),   32'h1);
    check("single_rv_c1",  32'(rvalid_a), 32'h0);
    step();
    check("single_rvalid", 32'(rvalid_a), 32'h1);
    check("single_rdata",  32'(rdata_a),  32'h85);
    step();
    check("single_rv_off", 32'(rvalid_a), 32'h0);

    // Requester 1 alone, which also brings rr_ptr back to 0.
    req_a = 2'b10; addr_a = {16'h0030, 16'h0020};
    #1;
    check("r1_gnt", 32'(gnt_a), 32'h2);
    step();
    req_a = 2'b00;
    step(); step(); step();

    // Contention: both held for 4 cycles, alternating grants.
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    for (int k = 0; k < 6; k++) begin
      req_a = (k < 4) ? 2'b11 : 2'b00;
      #1;
      check($sformatf("cont_gnt%0d", k), 32'(gnt_a), (k < 4) ? 32'(exp_g[k]) : 32'h0);
      if (k >= 2) begin
        check($sformatf("cont_rv%0d", k), 32'(rvalid_a), 32'(exp_g[k-2]));
        check($sformatf("cont_rd%0d", k), 32'(rdata_a),
              (exp_g[k-2] == 2'b01) ? 32'hE5 : 32'hF5);
      end
      step();
    end
    step();

    // Lock burst: requester 0 reads 0x10..0x12 with lock 1,1,0; req1 waits.
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_d[0] = 8'hD5; exp_d[1] = 8'hD4; exp_d[2] = 8'hD7; exp_d[3] = 8'hF5;
    for (int k = 0; k < 6; k++) begin
      req_a[1] = (k < 4);
      req_a[0] = (k < 3);
      lock_a   = (k < 2) ? 2'b01 : 2'b00;
      addr_a   = {16'h0030, 16'h0010 + 16'(k)};
      #1;
      if (k < 4) check($sformatf("lock_gnt%0d", k), 32'(gnt_a), 32'(exp_g[k]));
      if (k >= 2) begin
        check($sformatf("lock_rv%0d", k), 32'(rvalid_a), 32'(exp_g[k-2]));
        check($sformatf("lock_rd%0d", k), 32'(rdata_a),  32'(exp_d[k-2]));
      end
      step();
    end
    req_a = '0; lock_a = '0;
    step(); step();

    // Idle lock: requester 1 locks then idles; requester 0 must wait.
    req_a = 2'b10; lock_a = 2'b10;
    #1;
    check("idle_gnt_own", 32'(gnt_a), 32'h2);
    step();
    req_a = 2'b01; lock_a = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("idle_stall%0d", k), 32'(gnt_a), 32'h0);
      step();
    end
    check("idle_busy", 32'(busy_a), 32'h1);
    req_a = 2'b11; lock_a = 2'b00;
    #1;
    check("idle_release", 32'(gnt_a), 32'h2);
    step();
    req_a = 2'b01;
    #1;
    check("idle_after", 32'(gnt_a), 32'h1);
    step();
    req_a = '0;
    step(); step(); step();

    // Mid-flight reset: locked grant to requester 1, reset one cycle later.
    req_a = 2'b10; lock_a = 2'b10;
    #1;
    check("mrst_gnt", 32'(gnt_a), 32'h2);
    step();
    req_a = '0; lock_a = '0;
    reset = 1'b1;
    #1;
    check("mrst_busy_in", 32'(busy_a), 32'h0);
    step();
    check("mrst_rv_in", 32'(rvalid_a), 32'h0);
    reset = 1'b0;
    step();
    check("mrst_rv_after", 32'(rvalid_a), 32'h0);
    check("mrst_busy",     32'(busy_a),   32'h0);
    req_a = 2'b11;
    #1;
    check("mrst_first", 32'(gnt_a), 32'h1);
    step();
    req_a = '0;
    step(); step();

    // MEM_LAT=3: grants 0,1,0 back to back, data at +4,+5,+6.
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_d[0] = 8'h95; exp_d[1] = 8'hA5; exp_d[2] = 8'h94;
    for (int k = 0; k < 8; k++) begin
      req_b  = (k < 3) ? exp_g[k] : 2'b00;
      addr_b = {16'h0060, (k == 2) ? 16'h0051 : 16'h0050};
      #1;
      if (k < 3) check($sformatf("lat3_gnt%0d", k), 32'(gnt_b), 32'(exp_g[k]));
      if (k == 3) check("lat3_rv_early", 32'(rvalid_b), 32'h0);
      if (k >= 4 && k < 7) begin
        check($sformatf("lat3_rv%0d", k), 32'(rvalid_b), 32'(exp_g[k-4]));
        check($sformatf("lat3_rd%0d", k), 32'(rdata_b),  32'(exp_d[k-4]));
      end
      if (k == 7) begin
        check("lat3_rv_off",  32'(rvalid_b), 32'h0);
        check("lat3_rd_hold", 32'(rdata_b),  32'h94);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
